// File: rtl/fifo_arbiter_mux_pkg.sv
// fifo_arbiter_mux_pkg: shared state type, priority index and round-robin search helper
package fifo_arbiter_mux_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam int PRIO_IDX = 0;
  function automatic int rr_next(input logic [31:0] req, input int ptr, input int n);
    int idx;
    rr_next = 0;
    for (int i = 30; i >= 0; i--)
      if (i < n - 1) begin
        idx = ptr + i >= n ? ptr + i - (n - 1) : ptr + i;
        if (req[idx]) rr_next = idx;
      end
  endfunction
endpackage

// File: rtl/fifo_arbiter_mux_obuf.sv
// fifo_arbiter_mux_obuf: 2-entry first-word-fall-through buffer between source and output pops
module fifo_arbiter_mux_obuf #(
  parameter int DW = 32
) (
  input  logic          BUS_CLK,
  input  logic          BUS_RST_N,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);
  logic [DW-1:0] mem [2];
  logic rd_ptr, wr_ptr, do_push, do_pop;
  assign do_push = push & (count != 2'd2);
  assign do_pop = pop & (count != 2'd0);
  assign head = mem[rd_ptr];
  always_ff @(posedge BUS_CLK)
    if (!BUS_RST_N) begin
      mem <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) mem[wr_ptr] <= push_data;
      wr_ptr <= wr_ptr ^ do_push;
      rd_ptr <= rd_ptr ^ do_pop;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/fifo_arbiter_mux.sv
// fifo_arbiter_mux: burst-locked priority/round-robin arbiter muxing source FIFOs into one output FIFO
module fifo_arbiter_mux
  import fifo_arbiter_mux_pkg::*;
#(
  parameter int N_SRC     = 5,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int CW        = 32
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST_N,
  input  logic [N_SRC-1:0]    SRC_EMPTY,
  input  logic [N_SRC*DW-1:0] SRC_DATA,
  output logic [N_SRC-1:0]    SRC_READ,
  input  logic                PREEMPT_REQ,
  input  logic                OUT_READ,
  output logic                OUT_EMPTY,
  output logic [DW-1:0]       OUT_DATA,
  output logic [N_SRC-1:0]    GRANT,
  output logic [CW-1:0]       WORD_CNT
);
  localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state;
  logic [IW-1:0] g_idx, rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [1:0] count;
  logic space, popped, out_pop, release_grant;
  logic [DW-1:0] push_data;
  logic [N_SRC-1:0] req;
  int rr_pick;
  assign space = count != 2'd2;
  assign SRC_READ = GRANT & ~SRC_EMPTY & {N_SRC{space && state == LOCKED && BUS_RST_N}};
  assign popped = |SRC_READ;
  assign OUT_EMPTY = count == 2'd0;
  assign out_pop = OUT_READ & ~OUT_EMPTY;
  assign req = ~SRC_EMPTY & (PREEMPT_REQ ? N_SRC'(1) << PRIO_IDX : '1);
  assign rr_pick = rr_next(32'(req), int'(rr_ptr), N_SRC);
  assign release_grant = ~|(GRANT & ~SRC_EMPTY) | (popped && int'(burst_cnt) + 1 == MAX_BURST) |
                         (PREEMPT_REQ && int'(g_idx) != PRIO_IDX);
  always_comb begin
    push_data = '0;
    for (int i = 0; i < N_SRC; i++) push_data |= SRC_DATA[i*DW +: DW] & {DW{SRC_READ[i]}};
  end
  always_ff @(posedge BUS_CLK)
    if (!BUS_RST_N) begin
      state <= IDLE;
      GRANT <= '0;
      g_idx <= '0;
      rr_ptr <= IW'(1);
      burst_cnt <= '0;
      WORD_CNT <= '0;
    end else begin
      WORD_CNT <= WORD_CNT + CW'(out_pop);
      if (state == IDLE) begin
        if (req[PRIO_IDX] || rr_pick != 0) begin
          state <= LOCKED;
          g_idx <= req[PRIO_IDX] ? IW'(PRIO_IDX) : IW'(rr_pick);
          GRANT <= req[PRIO_IDX] ? N_SRC'(1) << PRIO_IDX : N_SRC'(1) << rr_pick;
          burst_cnt <= '0;
        end
      end else if (release_grant) begin
        state <= IDLE;
        GRANT <= '0;
        if (int'(g_idx) != PRIO_IDX) rr_ptr <= int'(g_idx) == N_SRC - 1 ? IW'(1) : g_idx + 1'b1;
      end else begin
        burst_cnt <= burst_cnt + BW'(popped);
      end
    end
  fifo_arbiter_mux_obuf #(.DW(DW)) u_obuf (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST_N (BUS_RST_N),
    .push      (popped),
    .push_data (push_data),
    .pop       (out_pop),
    .head      (OUT_DATA),
    .count     (count)
  );
endmodule
